// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
// Multi-cycle shift sequencer. A job (data, amount, op) is taken over a
// valid/ready handshake, shifted by at most MAX_STEP bit positions per cycle,
// and the result is returned over a second valid/ready handshake.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1. in_ready is 1 only in IDLE. out_valid is 1 only in DONE, and
// out_data is held stable while out_valid && !out_ready. in_* need not be
// held after the accepting edge.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset, wins over all other inputs
//   in_valid   job offered
//   in_ready   job slot free (IDLE)
//   in_data    operand
//   in_amt     shift amount (two's complement for SDYN, else unsigned)
//   in_op      00 SHL, 01 SHR, 10 SSHR, 11 SDYN
//   cancel     abandon the in-flight job (SHIFT or DONE)
//   out_valid  result available (DONE)
//   out_ready  consumer takes result
//   out_data   result, keeps its last value when out_valid=0
//   busy       state != IDLE
//   dbg_state  current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
// -----------------------------------------------------------------------------
module shift_seq_ctrl #(
  parameter int WIDTH    = 8,
  parameter int AMT_W    = 5,
  parameter int MAX_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_op,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SHL  = 2'b00;
  localparam logic [1:0] OP_SSHR = 2'b10;
  localparam logic [1:0] OP_SDYN = 2'b11;

  // Remaining-count width: must hold values 0..WIDTH.
  localparam int RW = $clog2(WIDTH + 1);
  // Magnitude width: wide enough for both the amount and WIDTH.
  localparam int MW = AMT_W + RW;

  localparam logic [MW-1:0] WIDTH_M = MW'(WIDTH);
  localparam logic [RW-1:0] WIDTH_R = RW'(WIDTH);
  localparam logic [RW-1:0] STEP_R  = RW'(MAX_STEP);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_out;
  logic [RW-1:0]    r_rem;
  logic             r_left;
  logic             r_arith;

  // ---------------------------------------------------------------------------
  // Accept-time decode of the incoming job
  // ---------------------------------------------------------------------------
  logic             w_amt_neg;
  logic [AMT_W-1:0] w_amt_abs;
  logic [MW-1:0]    w_mag;
  logic [RW-1:0]    w_rem_init;
  logic             w_left_in;
  logic             w_arith_in;

  always_comb begin
    // Negative SDYN amounts mean a left shift by the negated amount. The most
    // negative value negates to itself, which read unsigned is 2^(AMT_W-1).
    w_amt_neg  = (in_op == OP_SDYN) && in_amt[AMT_W-1];
    w_amt_abs  = w_amt_neg ? ((~in_amt) + AMT_W'(1)) : in_amt;
    w_mag      = {{RW{1'b0}}, w_amt_abs};
    // Anything at or beyond WIDTH behaves exactly like shifting by WIDTH.
    w_rem_init = (w_mag >= WIDTH_M) ? WIDTH_R : w_mag[RW-1:0];
    w_left_in  = (in_op == OP_SHL) || w_amt_neg;
    w_arith_in = (in_op == OP_SSHR) ||
                 ((in_op == OP_SDYN) && !in_amt[AMT_W-1]);
  end

  // ---------------------------------------------------------------------------
  // Bounded-step shifter
  // ---------------------------------------------------------------------------
  logic [RW-1:0]    w_step;
  logic             w_last;
  logic [WIDTH-1:0] w_shifted;

  always_comb begin
    w_step    = (r_rem < STEP_R) ? r_rem : STEP_R;
    w_last    = (r_rem <= STEP_R);
    w_shifted = r_data;
    if (r_left) begin
      w_shifted = r_data << w_step;
    end else if (r_arith) begin
      w_shifted = WIDTH'($signed(r_data) >>> w_step);
    end else begin
      w_shifted = r_data >> w_step;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        // cancel is deliberately ignored here so it cannot block an accept.
        if (in_valid) begin
          w_state_nxt = (w_rem_init != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        if (cancel) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (cancel || out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
    dbg_state = r_state;
    out_data  = r_out;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_out   <= '0;
      r_rem   <= '0;
      r_left  <= 1'b0;
      r_arith <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_data  <= in_data;
            r_rem   <= w_rem_init;
            r_left  <= w_left_in;
            r_arith <= w_arith_in;
            // Zero-amount jobs go straight to DONE with the operand unchanged.
            if (w_rem_init == '0) begin
              r_out <= in_data;
            end
          end
        end
        S_SHIFT: begin
          if (cancel) begin
            r_rem <= '0;
          end else begin
            r_data <= w_shifted;
            r_rem  <= r_rem - w_step;
            // The result register only changes when a job completes, so
            // out_data keeps the last delivered value in IDLE and SHIFT.
            if (w_last) begin
              r_out <= w_shifted;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_seq_ctrl
// Bench for shift_seq_ctrl (WIDTH=8, AMT_W=5, MAX_STEP=4). Directed vectors
// from a table, hand-written multi-cycle sequences (stall, reset, cancel) and
// random jobs checked against a whole-shift reference model.
// -----------------------------------------------------------------------------
module tb_shift_seq_ctrl;

  localparam logic [1:0] SHL  = 2'b00;
  localparam logic [1:0] SHR  = 2'b01;
  localparam logic [1:0] SSHR = 2'b10;
  localparam logic [1:0] SDYN = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [4:0] in_amt;
  logic [1:0] in_op;
  logic       cancel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic [1:0] dbg_state;

  shift_seq_ctrl #(.WIDTH(8), .AMT_W(5), .MAX_STEP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .cancel    (cancel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / watchdog
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  int         n_chk  = 0;
  int         n_pass = 0;

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [4:0] amt;
    logic [7:0] exp;
    int         lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: full-width shift in one go, saturating at 8 positions.
  function automatic int mag_of(input logic [1:0] op, input logic [4:0] amt);
    if (op == SDYN && amt[4]) return 32 - int'(amt);
    return int'(amt);
  endfunction

  function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] d,
                                       input logic [4:0] amt);
    int   mag;
    logic left;
    logic ar;
    mag  = mag_of(op, amt);
    left = (op == SHL) || (op == SDYN && amt[4]);
    ar   = (op == SSHR) || (op == SDYN && !amt[4]);
    if (mag >= 8) return (left || !ar) ? 8'h00 : {8{d[7]}};
    if (left) return 8'(d << mag);
    if (ar) return 8'($signed(d) >>> mag);
    return 8'(d >> mag);
  endfunction

  function automatic int lat_model(input logic [1:0] op, input logic [4:0] amt);
    int rem;
    rem = mag_of(op, amt);
    if (rem > 8) rem = 8;
    return 1 + (rem + 3) / 4;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a job for exactly one edge, then scramble the inputs.
  task automatic present(input logic [1:0] op, input logic [7:0] d, input logic [4:0] amt);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_amt   = amt;
    tick();
    in_valid = 1'b0;
    in_op    = 2'($urandom_range(0, 3));
    in_data  = 8'($urandom_range(0, 255));
    in_amt   = 5'($urandom_range(0, 31));
  endtask

  task automatic pop_cmp(input string name);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL %s: result 0x%0h with empty expected queue", name, out_data);
    end else begin
      e = exp_q.pop_front();
      chk(name, {24'h0, out_data}, {24'h0, e});
    end
  endtask

  // Wait for out_valid (the accept edge counts as cycle 1), check the latency
  // and the data; leaves the DUT in DONE.
  task automatic wait_result(input string name, input int exp_lat);
    int cyc;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({name, "_lat"}, out_valid ? cyc : 999, exp_lat);
    pop_cmp({name, "_data"});
  endtask

  task automatic run_job(input string name, input logic [1:0] op, input logic [7:0] d,
                         input logic [4:0] amt, input logic [7:0] exp, input int exp_lat);
    chk({name, "_in_ready"}, {31'h0, in_ready}, 1);
    exp_q.push_back(exp);
    present(op, d, amt);
    wait_result(name, exp_lat);
    tick();  // handoff with out_ready=1
    chk({name, "_handoff"}, {31'h0, out_valid}, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    vecs[0]  = '{SHL,  8'h81, 5'd3,  8'h08, 2};
    vecs[1]  = '{SSHR, 8'h90, 5'd6,  8'hFE, 3};
    vecs[2]  = '{SHR,  8'h90, 5'd6,  8'h02, 3};
    vecs[3]  = '{SSHR, 8'h80, 5'd15, 8'hFF, 3};
    vecs[4]  = '{SHR,  8'h80, 5'd15, 8'h00, 3};
    vecs[5]  = '{SHL,  8'h80, 5'd0,  8'h80, 1};
    vecs[6]  = '{SDYN, 8'h03, 5'h1E, 8'h0C, 2};
    vecs[7]  = '{SDYN, 8'h80, 5'd1,  8'hC0, 2};
    vecs[8]  = '{SDYN, 8'hA5, 5'h10, 8'h00, 3};
    vecs[9]  = '{SDYN, 8'h80, 5'd15, 8'hFF, 3};
    vecs[10] = '{SHL,  8'h01, 5'd7,  8'h80, 3};
    vecs[11] = '{SHL,  8'h01, 5'd8,  8'h00, 3};
    vecs[12] = '{SHR,  8'hFF, 5'd4,  8'h0F, 2};
    vecs[13] = '{SSHR, 8'h7F, 5'd31, 8'h00, 3};
    vecs[14] = '{SDYN, 8'h81, 5'd0,  8'h81, 1};
    vecs[15] = '{SSHR, 8'hC0, 5'd5,  8'hFE, 3};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_amt    = 5'd0;
    in_op     = SHL;
    cancel    = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready",  {31'h0, in_ready},  1);
    chk("rst_out_valid", {31'h0, out_valid}, 0);
    chk("rst_out_data",  {24'h0, out_data},  0);
    chk("rst_busy",      {31'h0, busy},      0);

    // Directed table
    for (int i = 0; i < 16; i++) begin
      run_job($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].amt,
              vecs[i].exp, vecs[i].lat);
    end

    // Consumer stall in DONE: data held, offered job ignored.
    out_ready = 1'b0;
    exp_q.push_back(8'h08);
    present(SHL, 8'h81, 5'd3);
    wait_result("stall", 2);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_op    = SHR;
      in_data  = 8'hFF;
      in_amt   = 5'd1;
      tick();
      chk($sformatf("stall%0d_valid", i), {31'h0, out_valid}, 1);
      chk($sformatf("stall%0d_in_ready", i), {31'h0, in_ready}, 0);
      chk($sformatf("stall%0d_data", i), {24'h0, out_data}, 32'h08);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("stall_release_valid", {31'h0, out_valid}, 0);
    chk("stall_release_in_ready", {31'h0, in_ready}, 1);
    chk("stall_release_data_kept", {24'h0, out_data}, 32'h08);
    run_job("after_stall", SSHR, 8'h90, 5'd6, 8'hFE, 3);

    // Reset in mid-SHIFT
    present(SSHR, 8'h80, 5'd15);
    chk("mid_rst_busy_before", {31'h0, busy}, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready",  {31'h0, in_ready},  1);
    chk("mid_rst_out_valid", {31'h0, out_valid}, 0);
    chk("mid_rst_busy",      {31'h0, busy},      0);
    chk("mid_rst_out_data",  {24'h0, out_data},  0);
    run_job("after_rst", SHL, 8'h81, 5'd3, 8'h08, 2);

    // Cancel in mid-SHIFT: result never appears, old result kept.
    present(SHL, 8'h01, 5'd7);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_in_ready",  {31'h0, in_ready},  1);
    chk("cancel_out_valid", {31'h0, out_valid}, 0);
    chk("cancel_out_data",  {24'h0, out_data},  32'h08);
    repeat (3) tick();
    chk("cancel_no_late_result", {31'h0, out_valid}, 0);
    run_job("after_cancel", SDYN, 8'h03, 5'h1E, 8'h0C, 2);

    // Cancel in DONE together with out_ready.
    present(SHL, 8'h03, 5'd0);
    chk("cancel_done_valid_before", {31'h0, out_valid}, 1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_done_out_valid", {31'h0, out_valid}, 0);
    chk("cancel_done_in_ready",  {31'h0, in_ready},  1);

    // Cancel in IDLE does not block a simultaneous accept.
    exp_q.push_back(8'h24);
    cancel = 1'b1;
    present(SHR, 8'h90, 5'd2);
    cancel = 1'b0;
    wait_result("cancel_idle", 2);
    tick();

    // Random jobs against the reference model
    for (int i = 0; i < 24; i++) begin
      logic [1:0] op;
      logic [7:0] d;
      logic [4:0] a;
      op = 2'($urandom_range(0, 3));
      d  = 8'($urandom_range(0, 255));
      a  = 5'($urandom_range(0, 31));
      run_job($sformatf("rnd%0d", i), op, d, a, model(op, d, a), lat_model(op, a));
    end

    chk("sb_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
